// File: rtl/knn_mem_responder_if.sv
// rtl/knn_mem_responder_if.sv - proc2mem/mem2proc tagged memory bus between initiator and responder
interface knn_mem_responder_if;
    logic [1:0]  proc2mem_command;
    logic [31:0] proc2mem_addr;
    logic [63:0] proc2mem_data;
    logic [3:0]  mem2proc_transaction_tag;
    logic [63:0] mem2proc_data;
    logic [3:0]  mem2proc_data_tag;

    modport master (
        output proc2mem_command, proc2mem_addr, proc2mem_data,
        input  mem2proc_transaction_tag, mem2proc_data, mem2proc_data_tag
    );

    modport slave (
        input  proc2mem_command, proc2mem_addr, proc2mem_data,
        output mem2proc_transaction_tag, mem2proc_data, mem2proc_data_tag
    );
endinterface

// File: rtl/knn_mem_responder.sv
// rtl/knn_mem_responder.sv - tagged fixed-latency memory responder; MEM_RESP_STALL_EN adds periodic load rejects
module knn_mem_responder #(
    parameter int MEM_LATENCY  = 10,
    parameter int NUM_TAGS     = 15,
    parameter int DEPTH_BLOCKS = 4096,
    parameter int STALL_PERIOD = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    knn_mem_responder_if.slave   bus,
    output logic [6:0]           outstanding_cnt
);
    localparam logic [1:0] MEM_LOAD  = 2'h1;
    localparam logic [1:0] MEM_STORE = 2'h2;
    localparam int TAG_W = 4;
    localparam int IDX_W = $clog2(DEPTH_BLOCKS);

    typedef struct packed {
        logic             vld;
        logic [TAG_W-1:0] tag;
        logic [63:0]      data;
    } ret_t;

    if (MEM_LATENCY < 1 || MEM_LATENCY > 64) begin : g_bad_latency
        $error("MEM_LATENCY out of range 1..64");
    end
    if (NUM_TAGS < 1 || NUM_TAGS > (2**TAG_W) - 1) begin : g_bad_tags
        $error("NUM_TAGS out of range");
    end
    if (STALL_PERIOD < 1) begin : g_bad_stall
        $error("STALL_PERIOD must be at least 1");
    end

    logic [63:0]         mem_q [DEPTH_BLOCKS];
    ret_t                pipe_q [MEM_LATENCY];
    ret_t                pipe_d [MEM_LATENCY];
    logic [NUM_TAGS-1:0] busy_q, busy_d;
    logic [6:0]          cnt_q, cnt_d;

    logic [IDX_W-1:0]    idx;
    logic [TAG_W-1:0]    free_tag;
    logic                have_free;
    logic                stall;
    logic                accept;
    logic                store_en;
    logic                retire;
    logic [TAG_W-1:0]    retire_tag;
    logic                unused_addr;

    // Block index: byte offset and bits above the array depth are dropped so addresses alias.
    assign idx         = bus.proc2mem_addr[IDX_W+2:3];
    assign unused_addr = ^{bus.proc2mem_addr[31:IDX_W+3], bus.proc2mem_addr[2:0]};

`ifdef MEM_RESP_STALL_EN
    localparam int SCW = $clog2(STALL_PERIOD + 1);
    logic [SCW-1:0] stall_cnt_q, stall_cnt_d;

    // Free-running modulo-STALL_PERIOD counter; the last slot of each period rejects loads.
    always_comb begin
        stall_cnt_d = stall_cnt_q + 1'b1;
        if (stall_cnt_q == SCW'(STALL_PERIOD - 1)) stall_cnt_d = '0;
    end

    // Stall counter register.
    always_ff @(posedge clk) begin
        if (reset) stall_cnt_q <= '0;
        else       stall_cnt_q <= stall_cnt_d;
    end

    assign stall = (stall_cnt_q == SCW'(STALL_PERIOD - 1));
`else
    assign stall = 1'b0;
`endif

    // Lowest free tag search and same-cycle accept decision.
    always_comb begin
        free_tag  = '0;
        have_free = 1'b0;
        for (int t = NUM_TAGS; t >= 1; t--) begin
            if (!busy_q[t-1]) begin
                free_tag  = TAG_W'(t);
                have_free = 1'b1;
            end
        end
        accept   = !reset && (bus.proc2mem_command == MEM_LOAD) && have_free && !stall;
        store_en = !reset && (bus.proc2mem_command == MEM_STORE);
        bus.mem2proc_transaction_tag = accept ? free_tag : '0;
    end

    // Return pipeline shift, tag bookkeeping and outstanding count.
    always_comb begin
        pipe_d[0] = '0;
        if (accept) pipe_d[0] = {1'b1, free_tag, mem_q[idx]};
        for (int i = 1; i < MEM_LATENCY; i++) pipe_d[i] = pipe_q[i-1];

        // The tag on the bus stays busy for its whole return cycle and frees at the following edge.
        retire     = pipe_q[MEM_LATENCY-1].vld;
        retire_tag = pipe_q[MEM_LATENCY-1].tag;
        busy_d     = busy_q;
        if (retire) busy_d[int'(retire_tag) - 1] = 1'b0;
        if (accept) busy_d[int'(free_tag) - 1]   = 1'b1;

        cnt_d = cnt_q;
        if (accept && !retire) cnt_d = cnt_q + 7'd1;
        if (!accept && retire) cnt_d = cnt_q - 7'd1;
    end

    // Control state; reset drops everything in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MEM_LATENCY; i++) pipe_q[i] <= '0;
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            pipe_q <= pipe_d;
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage array; not reset so contents survive a reset.
    always_ff @(posedge clk) begin
        if (store_en) mem_q[idx] <= bus.proc2mem_data;
    end

    assign bus.mem2proc_data     = pipe_q[MEM_LATENCY-1].data;
    assign bus.mem2proc_data_tag = pipe_q[MEM_LATENCY-1].tag;
    assign outstanding_cnt       = cnt_q;
endmodule
